// File: rtl/mole_sequencer.sv
// mole_sequencer
// Decides which hole shows a mole, how long it stays up, and whether each
// appearance ends in a hit or a miss. The game pace comes from a tick
// prescaler. Each correct whack shortens the mole dwell time, down to a
// floor. A pause level freezes the whole game, including the LFSR.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   start      in   start pulse, honoured only in IDLE or OVER
//   pause      in   level; freezes timers, LFSR, state and hit detection
//   hit_valid  in   one-cycle whack strobe
//   hit_pos    in   [2:0] hole whacked, 1..5
//   mole_pos   out  [2:0] 0 = no mole, 1..5 = hole showing the mole
//   hit_ok     out  one-cycle pulse on a correct whack
//   miss       out  one-cycle pulse when a mole expires unwhacked
//   miss_count out  [1:0] misses this game
//   game_over  out  high while in OVER
module mole_sequencer #(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned DWELL_INIT = 100,
  parameter int unsigned DWELL_MIN  = 30,
  parameter int unsigned DWELL_STEP = 5,
  parameter int unsigned GAP_TICKS  = 20,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       hit_valid,
  input  logic [2:0] hit_pos,
  output logic [2:0] mole_pos,
  output logic       hit_ok,
  output logic       miss,
  output logic [1:0] miss_count,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [19:0] TICK_LAST    = 20'(TICK_DIV - 1);
  localparam logic [7:0]  DWELL_INIT_V = 8'(DWELL_INIT);
  localparam logic [7:0]  DWELL_MIN_V  = 8'(DWELL_MIN);
  localparam logic [7:0]  DWELL_STEP_V = 8'(DWELL_STEP);
  // Smallest dwell that can still take a full step without going below the floor
  localparam logic [8:0]  DWELL_FLOOR  = 9'(DWELL_MIN + DWELL_STEP);
  localparam logic [7:0]  GAP_V        = 8'(GAP_TICKS);
  localparam logic [1:0]  MAX_MISS_V   = 2'(MAX_MISSES);

  state_t      state, state_n;
  logic [19:0] presc, presc_n;
  logic [7:0]  timer, timer_n;
  logic [7:0]  dwell, dwell_n;
  logic [7:0]  lfsr, lfsr_n;
  logic [2:0]  last_pos, last_pos_n;
  logic [2:0]  mole_pos_n;
  logic        hit_ok_n, miss_n, game_over_n;
  logic [1:0]  miss_count_n, miss_inc;
  logic [2:0]  cand, pick;
  logic        tick, expire, good_hit;
  logic        go_gap, go_show, go_over;

  // Next-state and output logic. Every register's next value is computed here.
  // Pause leaves all defaults in place, so the whole game holds still.
  always_comb begin
    state_n      = state;
    presc_n      = presc;
    timer_n      = timer;
    dwell_n      = dwell;
    lfsr_n       = lfsr;
    last_pos_n   = last_pos;
    mole_pos_n   = mole_pos;
    hit_ok_n     = 1'b0;
    miss_n       = 1'b0;
    miss_count_n = miss_count;
    game_over_n  = game_over;
    go_gap       = 1'b0;
    go_show      = 1'b0;
    go_over      = 1'b0;

    tick     = (presc == TICK_LAST);
    expire   = tick && (timer == 8'd1);
    good_hit = hit_valid && (hit_pos == mole_pos);
    miss_inc = miss_count + 2'd1;

    // (r mod 5) + 1 for a 3-bit r.
    // On a repeat of the last hole, move to the next hole and wrap 5 to 1.
    cand = (lfsr[2:0] >= 3'd5) ? (lfsr[2:0] - 3'd4) : (lfsr[2:0] + 3'd1);
    pick = (cand != last_pos) ? cand : ((cand == 3'd5) ? 3'd1 : cand + 3'd1);

    if (!pause) begin
      lfsr_n  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      presc_n = tick ? 20'd0 : presc + 20'd1;
      if (tick && (timer != 8'd0)) begin
        timer_n = timer - 8'd1;
      end

      case (state)
        IDLE, OVER: begin
          if (start) begin
            miss_count_n = 2'd0;
            dwell_n      = DWELL_INIT_V;
            go_gap       = 1'b1;
          end
        end
        GAP: begin
          if (expire) begin
            go_show = 1'b1;
          end
        end
        SHOW: begin
          // A correct hit on the expiry cycle takes priority over the miss
          if (good_hit) begin
            hit_ok_n = 1'b1;
            dwell_n  = ({1'b0, dwell} >= DWELL_FLOOR) ? (dwell - DWELL_STEP_V) : DWELL_MIN_V;
            go_gap   = 1'b1;
          end else if (expire) begin
            miss_n       = 1'b1;
            miss_count_n = miss_inc;
            if (miss_inc == MAX_MISS_V) begin
              go_over = 1'b1;
            end else begin
              go_gap = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase

      // Every state entry restarts the prescaler so each phase gets whole ticks
      if (go_gap) begin
        state_n     = GAP;
        presc_n     = 20'd0;
        timer_n     = GAP_V;
        mole_pos_n  = 3'd0;
        game_over_n = 1'b0;
      end
      if (go_show) begin
        state_n    = SHOW;
        presc_n    = 20'd0;
        timer_n    = dwell;
        mole_pos_n = pick;
        last_pos_n = pick;
      end
      if (go_over) begin
        state_n     = OVER;
        presc_n     = 20'd0;
        mole_pos_n  = 3'd0;
        game_over_n = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= 20'd0;
      timer      <= 8'd0;
      dwell      <= DWELL_INIT_V;
      lfsr       <= 8'h01;
      last_pos   <= 3'd0;
      mole_pos   <= 3'd0;
      hit_ok     <= 1'b0;
      miss       <= 1'b0;
      miss_count <= 2'd0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      timer      <= timer_n;
      dwell      <= dwell_n;
      lfsr       <= lfsr_n;
      last_pos   <= last_pos_n;
      mole_pos   <= mole_pos_n;
      hit_ok     <= hit_ok_n;
      miss       <= miss_n;
      miss_count <= miss_count_n;
      game_over  <= game_over_n;
    end
  end

endmodule
